// File: rtl/flash_read_arbiter_if.sv
// Bundle of request/response and flash-controller signals around flash_read_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/flash side.
interface flash_read_arbiter_if;
  logic        req0;
  logic        req1;
  logic [23:0] addr0;
  logic [23:0] addr1;
  logic        ack0;
  logic        ack1;
  logic        rvalid0;
  logic        rvalid1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        rerr0;
  logic        rerr1;
  logic        busy;
  logic        flash_re;
  logic [23:0] flash_addr;
  logic [31:0] flash_rdata;
  logic        flash_done;

  modport slave (
    input  req0, req1, addr0, addr1, flash_rdata, flash_done,
    output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, rerr0, rerr1,
           busy, flash_re, flash_addr
  );

  modport master (
    output req0, req1, addr0, addr1, flash_rdata, flash_done,
    input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, rerr0, rerr1,
           busy, flash_re, flash_addr
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Two-port read arbiter in front of an SPI flash controller, one read outstanding at a time.
// Define FLASH_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module flash_read_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flash_read_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [15:0] cnt_q, cnt_d;

  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic        rerr0_q, rerr0_d, rerr1_q, rerr1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        flash_re_q, flash_re_d;
  logic [23:0] flash_addr_q, flash_addr_d;
  logic        busy;

  logic        grant;
  logic        pick1;
  logic        resp_ev;

`ifdef FLASH_ARB_RR_EN
  // rr_q set means port 1 wins the next tie
  logic rr_q, rr_d;
  assign pick1 = bus.req1 && (!bus.req0 || rr_q);
`else
  assign pick1 = bus.req1 && !bus.req0;
`endif

  assign grant   = (state_q == S_IDLE) && (bus.req0 || bus.req1);
  assign resp_ev = (state_q == S_WAIT) && (bus.flash_done || (cnt_q == TO_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      cnt_q   <= 16'd0;
`ifdef FLASH_ARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
`ifdef FLASH_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
`ifdef FLASH_ARB_RR_EN
    rr_d    = grant ? !pick1 : rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_WAIT;
          gnt_d   = pick1;
          cnt_d   = 16'd0;
        end
      end
      S_WAIT: begin
        // a completion on the final count still counts as a normal response
        if (bus.flash_done)         state_d = S_RESP;
        else if (cnt_q == TO_LAST)  state_d = S_DRAIN;
        else                        cnt_d   = cnt_q + 16'd1;
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: if (bus.flash_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    flash_re_d   = grant;
    ack0_d       = grant && !pick1;
    ack1_d       = grant && pick1;
    flash_addr_d = grant ? (pick1 ? bus.addr1 : bus.addr0) : flash_addr_q;
    rvalid0_d    = resp_ev && !gnt_q;
    rvalid1_d    = resp_ev && gnt_q;
    rerr0_d      = resp_ev && !gnt_q && !bus.flash_done;
    rerr1_d      = resp_ev && gnt_q && !bus.flash_done;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    if (resp_ev && !gnt_q) rdata0_d = bus.flash_done ? bus.flash_rdata : 32'h0;
    if (resp_ev && gnt_q)  rdata1_d = bus.flash_done ? bus.flash_rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_re_q   <= 1'b0;
      flash_addr_q <= 24'h0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rerr0_q      <= 1'b0;
      rerr1_q      <= 1'b0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      flash_re_q   <= flash_re_d;
      flash_addr_q <= flash_addr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rerr0_q      <= rerr0_d;
      rerr1_q      <= rerr1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.flash_re   = flash_re_q;
  assign bus.flash_addr = flash_addr_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.rvalid0    = rvalid0_q;
  assign bus.rvalid1    = rvalid1_q;
  assign bus.rerr0      = rerr0_q;
  assign bus.rerr1      = rerr1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: one instance at default TIMEOUT, one at TIMEOUT=8.
module tb_flash_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [23:0] addr0, addr1;
  logic [31:0] frdata;
  logic        fdone;
  logic        p2;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  flash_read_arbiter_if bus_a ();
  flash_read_arbiter_if bus_t ();

  assign bus_a.req0        = req0;
  assign bus_a.req1        = req1;
  assign bus_a.addr0       = addr0;
  assign bus_a.addr1       = addr1;
  assign bus_a.flash_rdata = frdata;
  assign bus_a.flash_done  = fdone;
  assign bus_t.req0        = req0;
  assign bus_t.req1        = req1;
  assign bus_t.addr0       = addr0;
  assign bus_t.addr1       = addr1;
  assign bus_t.flash_rdata = frdata;
  assign bus_t.flash_done  = fdone;

  flash_read_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  flash_read_arbiter #(.TIMEOUT(8)) dut_to (.clk(clk), .rst_n(rst_n), .bus(bus_t));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse(input logic [31:0] d);
    fdone  = 1'b1;
    frdata = d;
    tick();
    fdone  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    frdata = '0; fdone = 1'b0;
    tick(); tick();
    chk("rst_busy",     32'(bus_a.busy),       32'd0);
    chk("rst_flash_re", 32'(bus_a.flash_re),   32'd0);
    chk("rst_addr",     32'(bus_a.flash_addr), 32'd0);
    chk("rst_ack0",     32'(bus_a.ack0),       32'd0);
    chk("rst_rvalid0",  32'(bus_a.rvalid0),    32'd0);
    chk("rst_rdata0",   bus_a.rdata0,          32'd0);
    chk("rst_rerr0",    32'(bus_a.rerr0),      32'd0);
    rst_n = 1'b1;
    tick();

    // completion while idle must be ignored
    done_pulse(32'h11111111);
    chk("idle_done_rv0",  32'(bus_a.rvalid0), 32'd0);
    chk("idle_done_rv1",  32'(bus_a.rvalid1), 32'd0);
    chk("idle_done_busy", 32'(bus_a.busy),    32'd0);

    // single read, port 0
    req0 = 1'b1; addr0 = 24'h001000;
    tick();
    chk("rd_ack0",   32'(bus_a.ack0),       32'd1);
    chk("rd_fre",    32'(bus_a.flash_re),   32'd1);
    chk("rd_ack1",   32'(bus_a.ack1),       32'd0);
    chk("rd_faddr",  32'(bus_a.flash_addr), 32'h001000);
    chk("rd_busy",   32'(bus_a.busy),       32'd1);
    req0 = 1'b0;
    tick();
    chk("rd_fre_off",  32'(bus_a.flash_re), 32'd0);
    chk("rd_ack0_off", 32'(bus_a.ack0),     32'd0);
    repeat (38) tick();
    done_pulse(32'hDEADBEEF);
    chk("rd_rv0",    32'(bus_a.rvalid0), 32'd1);
    chk("rd_rdata0", bus_a.rdata0,       32'hDEADBEEF);
    chk("rd_rerr0",  32'(bus_a.rerr0),   32'd0);
    chk("rd_rv1",    32'(bus_a.rvalid1), 32'd0);
    tick();
    chk("rd_rv0_off", 32'(bus_a.rvalid0), 32'd0);
    chk("rd_idle",    32'(bus_a.busy),    32'd0);
    chk("rd_faddr_hold", 32'(bus_a.flash_addr), 32'h001000);

    // tie handling
    req0 = 1'b1; req1 = 1'b1; addr0 = 24'h000100; addr1 = 24'h000200;
    tick();
    chk("tie1_ack0",  32'(bus_a.ack0),       32'd1);
    chk("tie1_ack1",  32'(bus_a.ack1),       32'd0);
    chk("tie1_faddr", 32'(bus_a.flash_addr), 32'h000100);
    req0 = 1'b0;
    tick();
    done_pulse(32'hA0A0A0A0);
    chk("tie1_rv0",    32'(bus_a.rvalid0), 32'd1);
    chk("tie1_rdata0", bus_a.rdata0,       32'hA0A0A0A0);
    tick();
    req0 = 1'b1;
`ifdef FLASH_ARB_RR_EN
    p2 = 1'b1;
`else
    p2 = 1'b0;
`endif
    tick();
    chk("tie2_ack0",  32'(bus_a.ack0), 32'(!p2));
    chk("tie2_ack1",  32'(bus_a.ack1), 32'(p2));
    chk("tie2_faddr", 32'(bus_a.flash_addr), p2 ? 32'h000200 : 32'h000100);
    if (p2) req1 = 1'b0; else req0 = 1'b0;
    tick();
    done_pulse(32'hB1B1B1B1);
    chk("tie2_rv",    32'(p2 ? bus_a.rvalid1 : bus_a.rvalid0), 32'd1);
    chk("tie2_rvx",   32'(p2 ? bus_a.rvalid0 : bus_a.rvalid1), 32'd0);
    chk("tie2_rdata", p2 ? bus_a.rdata1 : bus_a.rdata0,        32'hB1B1B1B1);
    tick();
    tick();
    chk("tie3_ack", 32'(p2 ? bus_a.ack0 : bus_a.ack1), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    done_pulse(32'hC2C2C2C2);
    chk("tie3_rv",    32'(p2 ? bus_a.rvalid0 : bus_a.rvalid1), 32'd1);
    chk("tie3_rdata", p2 ? bus_a.rdata0 : bus_a.rdata1,        32'hC2C2C2C2);
    chk("tie3_hold",  p2 ? bus_a.rdata1 : bus_a.rdata0,        32'hB1B1B1B1);
    tick();

    // back-to-back on port 1
    req1 = 1'b1; addr1 = 24'hABCDEF;
    tick();
    chk("b2b_ack1", 32'(bus_a.ack1), 32'd1);
    tick();
    done_pulse(32'h12345678);
    chk("b2b_rv1",    32'(bus_a.rvalid1), 32'd1);
    chk("b2b_rdata1", bus_a.rdata1,       32'h12345678);
    tick();
    chk("b2b_gap_fre", 32'(bus_a.flash_re), 32'd0);
    tick();
    chk("b2b_fre",   32'(bus_a.flash_re),   32'd1);
    chk("b2b_ack1b", 32'(bus_a.ack1),       32'd1);
    chk("b2b_faddr", 32'(bus_a.flash_addr), 32'hABCDEF);
    req1 = 1'b0;
    tick();
    done_pulse(32'h55AA55AA);
    chk("b2b_rv1b", 32'(bus_a.rvalid1), 32'd1);
    tick();

    // TIMEOUT=8 instance: completion on the last count, then a true timeout
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req0 = 1'b1; addr0 = 24'h000055;
    tick();
    chk("to_ack0", 32'(bus_t.ack0), 32'd1);
    req0 = 1'b0;
    repeat (7) tick();
    done_pulse(32'h77777777);
    chk("edge_rv0",    32'(bus_t.rvalid0), 32'd1);
    chk("edge_rerr0",  32'(bus_t.rerr0),   32'd0);
    chk("edge_rdata0", bus_t.rdata0,       32'h77777777);
    tick();
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (7) tick();
    chk("to_early_rv0", 32'(bus_t.rvalid0), 32'd0);
    tick();
    chk("to_rv0",    32'(bus_t.rvalid0), 32'd1);
    chk("to_rerr0",  32'(bus_t.rerr0),   32'd1);
    chk("to_rdata0", bus_t.rdata0,       32'd0);
    chk("to_rv1",    32'(bus_t.rvalid1), 32'd0);
    tick();
    chk("drain_rv0",  32'(bus_t.rvalid0), 32'd0);
    chk("drain_busy", 32'(bus_t.busy),    32'd1);
    repeat (3) tick();
    chk("drain_busy2", 32'(bus_t.busy), 32'd1);
    done_pulse(32'h99999999);
    chk("drain_idle",  32'(bus_t.busy),    32'd0);
    chk("drain_rv0b",  32'(bus_t.rvalid0), 32'd0);
    chk("drain_rdata", bus_t.rdata0,       32'd0);
    tick();
    tick();

    // reset in the middle of a read
    req0 = 1'b1; addr0 = 24'h000321;
    tick();
    req0 = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy",  32'(bus_a.busy),       32'd0);
    chk("mrst_faddr", 32'(bus_a.flash_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    done_pulse(32'hBAD0BAD0);
    chk("mrst_rv0",   32'(bus_a.rvalid0), 32'd0);
    chk("mrst_rdata", bus_a.rdata0,       32'd0);
    req0 = 1'b1; addr0 = 24'h000400;
    tick();
    chk("mrst_ack0", 32'(bus_a.ack0), 32'd1);
    req0 = 1'b0;
    repeat (3) tick();
    done_pulse(32'h0F0F0F0F);
    chk("mrst_rv0b",   32'(bus_a.rvalid0), 32'd1);
    chk("mrst_rdata0", bus_a.rdata0,       32'h0F0F0F0F);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
